// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with load, programmable modulus, wrap/saturate mode,
// terminal-count flag and registered one-cycle wrap pulse.
module updown_counter_mod #(
    parameter int unsigned BITS      = 4,
    parameter int unsigned MAX       = (1 << BITS) - 1,
    parameter int unsigned RESET_VAL = MAX,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            sel,
    input  logic            load,
    input  logic [BITS-1:0] load_val,
    output logic [BITS-1:0] count,
    output logic            tc,
    output logic            wrap
);

    localparam logic [BITS-1:0] MaxVal   = BITS'(MAX);
    localparam logic [BITS-1:0] ResetVal = BITS'(RESET_VAL);
    localparam logic [BITS-1:0] One      = BITS'(1);

    logic [BITS-1:0] count_q, count_d;
    logic            wrap_q, wrap_d;
    logic            at_max, at_zero;

    assign at_max  = (count_q == MaxVal);
    assign at_zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            // Clamp so the count never leaves 0..MAX, even for out-of-range loads.
            count_d = (load_val > MaxVal) ? MaxVal : load_val;
        end else if (en) begin
            if (sel) begin
                if (!at_max) begin
                    count_d = count_q + One;
                end else if (!SATURATE) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_d = count_q - One;
                end else if (!SATURATE) begin
                    count_d = MaxVal;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= ResetVal;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        count = count_q;
        wrap  = wrap_q;
        tc    = sel ? at_max : at_zero;
    end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench: three counter configurations (MAX=15 wrap, MAX=9 wrap, MAX=9 saturate)
// driven by shared inputs, checked against a vector table, directed sequences and a model.
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       reset = 1'b0, en = 1'b0, sel = 1'b0, load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] cnt0, cnt1, cnt2;
    logic       tc0, tc1, tc2, wr0, wr1, wr2;
    logic [3:0] dc[3];
    logic       dt[3], dw[3];

    int n_tests = 0;
    int n_fail  = 0;

    int mc[3];
    bit mw[3];
    int maxv[3] = '{15, 9, 9};
    int rstv[3] = '{15, 9, 9};
    bit sat[3]  = '{1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    updown_counter_mod #(.BITS(4), .MAX(15), .RESET_VAL(15), .SATURATE(1'b0)) u_d0 (
        .clk(clk), .reset(reset), .en(en), .sel(sel), .load(load), .load_val(load_val),
        .count(cnt0), .tc(tc0), .wrap(wr0)
    );
    updown_counter_mod #(.BITS(4), .MAX(9), .RESET_VAL(9), .SATURATE(1'b0)) u_d1 (
        .clk(clk), .reset(reset), .en(en), .sel(sel), .load(load), .load_val(load_val),
        .count(cnt1), .tc(tc1), .wrap(wr1)
    );
    updown_counter_mod #(.BITS(4), .MAX(9), .RESET_VAL(9), .SATURATE(1'b1)) u_d2 (
        .clk(clk), .reset(reset), .en(en), .sel(sel), .load(load), .load_val(load_val),
        .count(cnt2), .tc(tc2), .wrap(wr2)
    );

    assign dc[0] = cnt0;
    assign dc[1] = cnt1;
    assign dc[2] = cnt2;
    assign dt[0] = tc0;
    assign dt[1] = tc1;
    assign dt[2] = tc2;
    assign dw[0] = wr0;
    assign dw[1] = wr1;
    assign dw[2] = wr2;

    typedef struct {
        bit         rst;
        bit         ld;
        bit         e;
        bit         s;
        logic [3:0] lv;
        logic [3:0] e0;
        logic [3:0] e1;
        logic [3:0] e2;
        logic [2:0] ew;   // ew[i] is the wrap expected from instance i
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference behaviour: arithmetic modulo MAX+1 or clamped to 0..MAX.
    task automatic tick(input bit r, input bit l, input bit e, input bit s, input logic [3:0] v);
        reset = r; load = l; en = e; sel = s; load_val = v;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!r) begin
                mc[i] = rstv[i]; mw[i] = 1'b0;
            end else if (l) begin
                mc[i] = (int'(v) > maxv[i]) ? maxv[i] : int'(v); mw[i] = 1'b0;
            end else if (e && s) begin
                mw[i] = !sat[i] && mc[i] == maxv[i];
                mc[i] = sat[i] ? ((mc[i] + 1 > maxv[i]) ? maxv[i] : mc[i] + 1)
                               : (mc[i] + 1) % (maxv[i] + 1);
            end else if (e) begin
                mw[i] = !sat[i] && mc[i] == 0;
                mc[i] = sat[i] ? ((mc[i] - 1 < 0) ? 0 : mc[i] - 1)
                               : (mc[i] + maxv[i]) % (maxv[i] + 1);
            end else begin
                mw[i] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s count[%0d]", tag, i), 32'(dc[i]), 32'(mc[i]));
            check($sformatf("%s wrap[%0d]", tag, i), 32'(dw[i]), 32'(mw[i]));
            check($sformatf("%s tc[%0d]", tag, i), 32'(dt[i]),
                  32'(sel ? (mc[i] == maxv[i]) : (mc[i] == 0)));
        end
    endtask

    initial begin
        // rst ld en sel lv | count d0 d1 d2 | wrap
        vecs[0]  = '{0, 0, 0, 0, 4'd0,  4'd15, 4'd9, 4'd9, 3'b000};
        vecs[1]  = '{0, 0, 0, 0, 4'd0,  4'd15, 4'd9, 4'd9, 3'b000};
        vecs[2]  = '{1, 0, 1, 1, 4'd0,  4'd0,  4'd0, 4'd9, 3'b011};
        vecs[3]  = '{1, 0, 1, 1, 4'd0,  4'd1,  4'd1, 4'd9, 3'b000};
        vecs[4]  = '{1, 1, 0, 1, 4'd8,  4'd8,  4'd8, 4'd8, 3'b000};
        vecs[5]  = '{1, 0, 1, 1, 4'd0,  4'd9,  4'd9, 4'd9, 3'b000};
        vecs[6]  = '{1, 0, 1, 1, 4'd0,  4'd10, 4'd0, 4'd9, 3'b010};
        vecs[7]  = '{1, 0, 1, 1, 4'd0,  4'd11, 4'd1, 4'd9, 3'b000};
        vecs[8]  = '{1, 1, 1, 1, 4'd12, 4'd12, 4'd9, 4'd9, 3'b000};
        vecs[9]  = '{1, 1, 0, 0, 4'd1,  4'd1,  4'd1, 4'd1, 3'b000};
        vecs[10] = '{1, 0, 1, 0, 4'd0,  4'd0,  4'd0, 4'd0, 3'b000};
        vecs[11] = '{1, 0, 1, 0, 4'd0,  4'd15, 4'd9, 4'd0, 3'b011};
        vecs[12] = '{1, 0, 1, 0, 4'd0,  4'd14, 4'd8, 4'd0, 3'b000};
        vecs[13] = '{0, 1, 1, 1, 4'd3,  4'd15, 4'd9, 4'd9, 3'b000};
        vecs[14] = '{1, 0, 0, 0, 4'd5,  4'd15, 4'd9, 4'd9, 3'b000};
        vecs[15] = '{1, 1, 0, 0, 4'd0,  4'd0,  4'd0, 4'd0, 3'b000};
        vecs[16] = '{1, 0, 1, 0, 4'd0,  4'd15, 4'd9, 4'd0, 3'b011};

        @(negedge clk);
        for (int k = 0; k < 17; k++) begin
            logic [3:0] ec[3];
            tick(vecs[k].rst, vecs[k].ld, vecs[k].e, vecs[k].s, vecs[k].lv);
            ec[0] = vecs[k].e0; ec[1] = vecs[k].e1; ec[2] = vecs[k].e2;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("vec%0d count[%0d]", k, i), 32'(dc[i]), 32'(ec[i]));
                check($sformatf("vec%0d wrap[%0d]", k, i), 32'(dw[i]), 32'(vecs[k].ew[i]));
                check($sformatf("vec%0d tc[%0d]", k, i), 32'(dt[i]),
                      32'(vecs[k].s ? (ec[i] == 4'(maxv[i])) : (ec[i] == 4'd0)));
            end
        end

        // MAX=9 modulo run: 1..9,0 with wrap only on the 0 cycle, tc while at 9.
        tick(1, 1, 0, 1, 4'd0);
        for (int k = 0; k < 10; k++) begin
            tick(1, 0, 1, 1, 4'd0);
            check($sformatf("mod run %0d count", k), 32'(cnt1), (k < 9) ? k + 1 : 0);
            check($sformatf("mod run %0d wrap", k), 32'(wr1), 32'(k == 9));
            check($sformatf("mod run %0d tc", k), 32'(tc1), 32'(k == 8));
            check_model("mod run");
        end
        tick(1, 0, 1, 0, 4'd0);
        check("down from 0 count", 32'(cnt1), 32'd9);
        check("down from 0 wrap", 32'(wr1), 32'd1);

        // Idle with sel toggling: count frozen, tc follows sel immediately.
        tick(1, 1, 0, 0, 4'd0);
        for (int k = 0; k < 5; k++) begin
            sel = k[0];
            #1;
            check($sformatf("idle %0d tc", k), 32'(tc1), 32'(!k[0]));
            tick(1, 0, 0, k[0], 4'($urandom_range(0, 15)));
            check($sformatf("idle %0d count", k), 32'(cnt1), 32'd0);
            check($sformatf("idle %0d wrap", k), 32'(wr1), 32'd0);
        end

        // Mid-run reset at count 5.
        tick(1, 1, 0, 1, 4'd4);
        tick(1, 0, 1, 1, 4'd0);
        check("pre-reset count", 32'(cnt0), 32'd5);
        tick(0, 0, 1, 1, 4'd0);
        check("mid reset count", 32'(cnt0), 32'd15);
        check("mid reset wrap", 32'(wr0), 32'd0);
        check_model("mid reset");

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            tick(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
            check_model($sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
- Parametrised successor to the fixed 4-bit up/down counter.
- Adds count enable, synchronous parallel load, a programmable modulus (MAX), and a selectable wrap/saturate mode.
- Adds a terminal-count flag and a one-cycle wrap pulse.
- Used as a general-purpose event, address or timer counter in lab datapaths; feeds displays and control FSMs.

Parameters:
- BITS, 4, counter width in bits; must be at least 1.
- MAX, (1<<BITS)-1, highest count value; legal range 1 to (1<<BITS)-1.
- RESET_VAL, MAX, value loaded on reset; must be at most MAX. The default keeps the previous "reset to all ones" behaviour when MAX is full scale.
- SATURATE, 0, boundary mode: 0 wraps around, 1 holds at the limit.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-low reset.
- en, input, 1, count enable.
- sel, input, 1, direction: 1 counts up, 0 counts down.
- load, input, 1, synchronous parallel load.
- load_val, input, BITS, value to load.
- count, output, BITS, registered counter value.
- tc, output, 1, terminal count (combinational).
- wrap, output, 1, registered wrap pulse.

Behaviour:
- Clock and reset: one clock domain. All state updates on the rising edge of clk. reset is synchronous and active-low; it is sampled only at clk edges.
- Reset (reset==0 at an edge):
  - count <= RESET_VAL
  - wrap <= 0
  - Overrides load and en in that cycle.
  - A mid-operation reset discards any count in progress; the next cycle starts from RESET_VAL.
- Priority at each edge: reset, then load, then en.
- Load (reset==1, load==1):
  - count <= load_val if load_val <= MAX, else count <= MAX (clamp).
  - wrap <= 0.
  - Ignores en and sel.
- Count up (reset==1, load==0, en==1, sel==1):
  - count < MAX: count <= count+1, wrap <= 0.
  - count == MAX, SATURATE=0: count <= 0, wrap <= 1.
  - count == MAX, SATURATE=1: count holds at MAX, wrap <= 0.
- Count down (reset==1, load==0, en==1, sel==0):
  - count > 0: count <= count-1, wrap <= 0.
  - count == 0, SATURATE=0: count <= MAX, wrap <= 1.
  - count == 0, SATURATE=1: count holds at 0, wrap <= 0.
- Idle (en==0, load==0, reset==1): count holds; wrap <= 0.
- wrap timing: a single-cycle pulse, high in the same cycle that the wrapped value appears on count. Continuous wrapping (e.g. MAX=1 counting up) keeps wrap high on every wrapping edge.
- tc (combinational): tc = (sel && count==MAX) || (!sel && count==0).
  - Does not depend on en or SATURATE.
  - Reflects a sel change within the same cycle.
- Arithmetic and width rules:
  - All arithmetic is modulo MAX+1, never modulo 2^BITS.
  - count never exceeds MAX, including after load or reset.
  - No X propagation from load_val when load==0.
- Latency: one cycle from a control input to the count update; zero cycles to tc.
- Direction change mid-count: takes effect at the next enabled edge, with no extra cycle or glitch on count.

Test Plan:
- Reset: BITS=4, MAX=15, SATURATE=0; hold reset=0 for 2 edges, then release -> count=15, wrap=0. With sel=1, en=1 -> next edge count=0, wrap=1; following edge count=1, wrap=0.
- Modulo wrap: MAX=9, count up from 0 for 10 edges -> count sequence 1..9,0; wrap high only on the 0 cycle; tc high while count=9. Then sel=0 from 0 -> count=9, wrap=1.
- Saturate: MAX=9, SATURATE=1, load 8, up 3 edges -> count=9,9,9, wrap stays 0. Down from load 1, 3 edges -> 0,0,0, tc=1.
- Load clamp and priority: MAX=9; load_val=12, load=1, en=1 -> count=9. Then load=1 with reset=0 on the same edge -> count=RESET_VAL.
- Enable and idle: en=0 for 5 edges with sel toggling -> count unchanged, wrap=0; tc follows sel combinationally (count=0: sel=0 gives tc=1, sel=1 gives tc=0).
- Mid-run reset: counting up at count=5, assert reset for 1 edge -> count=RESET_VAL on that edge, with no residual wrap pulse.
